// File: rtl/param_shift_reg.sv
// Parameterised shift/rotate register with a serial-transfer burst controller.
// In IDLE the register performs the operation chosen by mode_21 each edge.
// A start_21 pulse loads din_21 and then shifts the word out LSB-first over
// exactly WIDTH edges. The shifts fill from MSBin_21. A done_21 pulse
// follows the last shift.
module param_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic                         clk_21,
  input  logic                         rst_21,
  input  logic [2:0]                   mode_21,
  input  logic [WIDTH-1:0]             din_21,
  input  logic                         MSBin_21,
  input  logic                         LSBin_21,
  input  logic                         start_21,
  output logic [WIDTH-1:0]             dout_21,
  output logic                         MSBout_21,
  output logic                         LSBout_21,
  output logic                         busy_21,
  output logic                         done_21,
  output logic [$clog2(WIDTH+1)-1:0]   cnt_21
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHR  = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_ROL  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   dout_r;
  logic [WIDTH-1:0]   dout_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_s;
  logic               busy_r;
  logic               busy_s;
  logic               done_r;
  logic               done_s;

  // Next-state, next-data and next-counter decode for both controller states.
  always_comb begin
    state_s = state_r;
    dout_s  = dout_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_21) begin
          // The load edge ignores mode_21 entirely.
          dout_s  = din_21;
          cnt_s   = CNT_LOAD;
          state_s = XFER;
        end else begin
          cnt_s = CNT_ZERO;
          case (mode_21)
            MODE_HOLD: dout_s = dout_r;
            MODE_SHR:  dout_s = {MSBin_21, dout_r[WIDTH-1:1]};
            MODE_SHL:  dout_s = {dout_r[WIDTH-2:0], LSBin_21};
            MODE_LOAD: dout_s = din_21;
            MODE_ROR:  dout_s = {dout_r[0], dout_r[WIDTH-1:1]};
            MODE_ROL:  dout_s = {dout_r[WIDTH-2:0], dout_r[WIDTH-1]};
            MODE_ASR:  dout_s = {dout_r[WIDTH-1], dout_r[WIDTH-1:1]};
            MODE_RSVD: dout_s = dout_r;
            default:   dout_s = dout_r;
          endcase
        end
      end
      XFER: begin
        // start_21 and mode_21 have no effect once a burst is running.
        dout_s = {MSBin_21, dout_r[WIDTH-1:1]};
        cnt_s  = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = XFER;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // busy mirrors the state being entered, so it is registered with the state.
  always_comb begin
    busy_s = 1'b0;
    if (state_s == XFER) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State and datapath registers; reset clears everything without a clock.
  always_ff @(posedge clk_21 or posedge rst_21) begin
    if (rst_21) begin
      state_r <= IDLE;
      dout_r  <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dout_r  <= dout_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign dout_21   = dout_r;
  assign MSBout_21 = dout_r[WIDTH-1];
  assign LSBout_21 = dout_r[0];
  assign busy_21   = busy_r;
  assign done_21   = done_r;
  assign cnt_21    = cnt_r;

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg. It drives a WIDTH=8 instance and a
// WIDTH=5 instance from shared control inputs, and each instance has its own
// data input. A word-level model predicts every output on every cycle.
// Directed steps also pin hand-computed values.
module tb_param_shift_reg;

  logic       clk;
  logic       rst;
  logic [2:0] mode;
  logic [7:0] din8;
  logic [4:0] din5;
  logic       msbin;
  logic       lsbin;
  logic       start;

  logic [7:0] dout8;
  logic       msbout8, lsbout8, busy8, done8;
  logic [3:0] cnt8;
  logic [4:0] dout5;
  logic       msbout5, lsbout5, busy5, done5;
  logic [2:0] cnt5;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  param_shift_reg #(.WIDTH(8)) u8 (
    .clk_21(clk), .rst_21(rst), .mode_21(mode), .din_21(din8),
    .MSBin_21(msbin), .LSBin_21(lsbin), .start_21(start),
    .dout_21(dout8), .MSBout_21(msbout8), .LSBout_21(lsbout8),
    .busy_21(busy8), .done_21(done8), .cnt_21(cnt8)
  );

  param_shift_reg #(.WIDTH(5)) u5 (
    .clk_21(clk), .rst_21(rst), .mode_21(mode), .din_21(din5),
    .MSBin_21(msbin), .LSBin_21(lsbin), .start_21(start),
    .dout_21(dout5), .MSBout_21(msbout5), .LSBout_21(lsbout5),
    .busy_21(busy5), .done_21(done5), .cnt_21(cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int wid(input int i);
    return (i == 0) ? 8 : 5;
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] idle_op(input int w, input logic [31:0] d, input logic [2:0] m,
                                          input logic [31:0] din, input logic msb, input logic lsb);
    logic [31:0] top;
    top = (d >> (w - 1)) & 32'd1;
    case (m)
      3'd1: return (d >> 1) | (32'(msb) << (w - 1));
      3'd2: return ((d << 1) | 32'(lsb)) & mask_of(w);
      3'd3: return din & mask_of(w);
      3'd4: return (d >> 1) | ((d & 32'd1) << (w - 1));
      3'd5: return ((d << 1) & mask_of(w)) | top;
      3'd6: return (d >> 1) | (top << (w - 1));
      default: return d;
    endcase
  endfunction

  logic [31:0] m_dout [2];
  int          m_rem  [2];
  bit          m_done [2];
  logic [31:0] m_din  [2];

  assign m_din[0] = 32'(din8);
  assign m_din[1] = 32'(din5);

  // Model update: m_rem is the number of burst shifts still owed.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_dout[i] <= 32'd0;
        m_rem[i]  <= 0;
        m_done[i] <= 1'b0;
      end else if (m_rem[i] != 0) begin
        m_dout[i] <= (m_dout[i] >> 1) | (32'(msbin) << (wid(i) - 1));
        m_rem[i]  <= m_rem[i] - 1;
        m_done[i] <= (m_rem[i] == 1);
      end else begin
        m_done[i] <= 1'b0;
        if (start) begin
          m_dout[i] <= m_din[i] & mask_of(wid(i));
          m_rem[i]  <= wid(i);
        end else begin
          m_dout[i] <= idle_op(wid(i), m_dout[i], mode, m_din[i], msbin, lsbin);
        end
      end
    end
  end

  logic [31:0] d_dout [2];
  logic [31:0] d_cnt  [2];
  logic        d_msb  [2];
  logic        d_lsb  [2];
  logic        d_busy [2];
  logic        d_done [2];
  assign d_dout[0] = 32'(dout8);  assign d_dout[1] = 32'(dout5);
  assign d_cnt[0]  = 32'(cnt8);   assign d_cnt[1]  = 32'(cnt5);
  assign d_msb[0]  = msbout8;     assign d_msb[1]  = msbout5;
  assign d_lsb[0]  = lsbout8;     assign d_lsb[1]  = lsbout5;
  assign d_busy[0] = busy8;       assign d_busy[1] = busy5;
  assign d_done[0] = done8;       assign d_done[1] = done5;

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("w%0d dout", wid(i)), d_dout[i], m_dout[i]);
        check($sformatf("w%0d msbout", wid(i)), 32'(d_msb[i]), (m_dout[i] >> (wid(i) - 1)) & 32'd1);
        check($sformatf("w%0d lsbout", wid(i)), 32'(d_lsb[i]), m_dout[i] & 32'd1);
        check($sformatf("w%0d cnt", wid(i)), d_cnt[i], 32'(m_rem[i]));
        check($sformatf("w%0d busy", wid(i)), 32'(d_busy[i]), 32'(m_rem[i] != 0));
        check($sformatf("w%0d done", wid(i)), 32'(d_done[i]), 32'(m_done[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v8, input logic [4:0] v5);
    mode = 3'd3; din8 = v8; din5 = v5; start = 1'b0;
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] exp8;
    logic [4:0] exp5;
    int busy_cnt;
    int done_cnt;

    rst = 1'b1; mode = 3'd0; din8 = 8'h00; din5 = 5'h00;
    msbin = 1'b0; lsbin = 1'b0; start = 1'b0;
    repeat (2) tick();
    check("reset dout", 32'(dout8), 32'h0);
    check("reset cnt", 32'(cnt8), 32'h0);
    check("reset busy", 32'(busy8), 32'h0);
    check("reset done", 32'(done8), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Load, rotate left, rotate right.
    load(8'hA5, 5'h13);
    check("load A5", 32'(dout8), 32'hA5);
    check("load5 13", 32'(dout5), 32'h13);
    mode = 3'd5; tick();
    check("rol 4B", 32'(dout8), 32'h4B);
    check("rol5 07", 32'(dout5), 32'h07);
    mode = 3'd4; tick();
    check("ror A5", 32'(dout8), 32'hA5);
    check("ror5 13", 32'(dout5), 32'h13);

    // Arithmetic shift, logical shifts.
    load(8'h81, 5'h11);
    mode = 3'd6; tick();
    check("asr C0", 32'(dout8), 32'hC0);
    check("asr5 18", 32'(dout5), 32'h18);
    load(8'h81, 5'h11);
    mode = 3'd1; msbin = 1'b0; tick();
    check("shr 40", 32'(dout8), 32'h40);
    check("shr5 08", 32'(dout5), 32'h08);
    load(8'h81, 5'h11);
    mode = 3'd2; lsbin = 1'b1; tick();
    check("shl 03", 32'(dout8), 32'h03);
    check("shl5 03", 32'(dout5), 32'h03);
    mode = 3'd0; tick();
    check("hold 03", 32'(dout8), 32'h03);
    mode = 3'd7; tick();
    check("rsvd hold 03", 32'(dout8), 32'h03);
    mode = 3'd1; msbin = 1'b1; tick();
    check("shr fill1 81", 32'(dout8), 32'h81);

    // Serial bursts on both widths at once.
    mode = 3'd0; msbin = 1'b0; din8 = 8'h96; din5 = 5'h13; start = 1'b1;
    tick();
    start = 1'b0;
    exp8 = 8'b1001_0110;
    exp5 = 5'b1_0011;
    for (int k = 0; k < 8; k++) begin
      check("burst8 busy", 32'(busy8), 32'h1);
      check("burst8 lsb", 32'(lsbout8), 32'(exp8[k]));
      check("burst8 cnt", 32'(cnt8), 32'(8 - k));
      if (k < 5) begin
        check("burst5 busy", 32'(busy5), 32'h1);
        check("burst5 lsb", 32'(lsbout5), 32'(exp5[k]));
        check("burst5 cnt", 32'(cnt5), 32'(5 - k));
      end else if (k == 5) begin
        check("burst5 done", 32'(done5), 32'h1);
        check("burst5 busy end", 32'(busy5), 32'h0);
        check("burst5 dout end", 32'(dout5), 32'h0);
      end else begin
        check("burst5 done low", 32'(done5), 32'h0);
      end
      tick();
    end
    check("burst8 done", 32'(done8), 32'h1);
    check("burst8 busy end", 32'(busy8), 32'h0);
    check("burst8 dout end", 32'(dout8), 32'h0);
    check("burst8 cnt end", 32'(cnt8), 32'h0);
    tick();
    check("burst8 done one cycle", 32'(done8), 32'h0);

    // A burst ignores start and load requests while it runs.
    mode = 3'd0; din8 = 8'h5A; din5 = 5'h0A; start = 1'b1;
    tick();
    mode = 3'd3; din8 = 8'hFF; din5 = 5'h1F;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy8) busy_cnt++;
      if (done8) done_cnt++;
      tick();
    end
    start = 1'b0; mode = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (busy8) busy_cnt++;
      if (done8) done_cnt++;
      tick();
    end
    check("norestart busy cycles", 32'(busy_cnt), 32'd8);
    check("norestart done pulses", 32'(done_cnt), 32'd1);
    check("norestart no reload", 32'(dout8), 32'h00);

    // Asynchronous reset in mid-burst, then a normal first edge after release.
    din8 = 8'hC3; din5 = 5'h15; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort cnt before rst", 32'(cnt8), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("async rst dout", 32'(dout8), 32'h0);
    check("async rst cnt", 32'(cnt8), 32'h0);
    check("async rst busy", 32'(busy8), 32'h0);
    check("async rst done", 32'(done8), 32'h0);
    check("async rst dout5", 32'(dout5), 32'h0);
    check("async rst busy5", 32'(busy5), 32'h0);
    mode = 3'd3; din8 = 8'h3C; din5 = 5'h0C; start = 1'b1;
    repeat (2) tick();
    check("rst ignores inputs", 32'(dout8), 32'h0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    check("first edge after rst", 32'(dout8), 32'h3C);
    mode = 3'd0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (done8 || busy8) done_cnt++;
      tick();
    end
    check("no done after abort", 32'(done_cnt), 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
